// File: rtl/seller_pkg.sv
// Shared definitions for the seller datapath key front-end.
// Optional feature macro: KEY_REPEAT_EN (auto-repeat while a key is held).
package seller_pkg;

    // Debouncer state encoding; values are fixed so they can be probed in the lab.
    typedef enum logic [1:0] {
        KEY_IDLE  = 2'd0,
        KEY_PRESS = 2'd1,
        KEY_HELD  = 2'd2,
        KEY_REL   = 2'd3
    } key_state_t;

    // 20 ms at 50 MHz for debounce, 0.5 s between auto-repeat pulses.
    localparam int unsigned DEF_DEB_CNT = 1_000_000;
    localparam int unsigned DEF_REP_CNT = 25_000_000;
    localparam int unsigned DEF_CNT_W   = 25;

    // Smallest legal debounce length: the sync stages plus a meaningful window.
    localparam int unsigned MIN_DEB_CNT = 4;

    // True when a counter of width w can reach n-1 without wrapping.
    function automatic bit cnt_fits(input int unsigned n, input int unsigned w);
        if (w >= 32) begin
            return 1'b1;
        end
        return (64'(n) <= (64'd1 << w));
    endfunction

endpackage : seller_pkg

// File: rtl/key_debounce.sv
// Per-key synchroniser, debounce FSM and counter; emits a one-cycle hit per confirmed press.
// With KEY_REPEAT_EN defined, a held key also produces a hit every REP_CNT cycles.
module key_debounce
    import seller_pkg::*;
#(
    parameter int unsigned DEB_CNT = DEF_DEB_CNT,
    parameter int unsigned CNT_W   = DEF_CNT_W
`ifdef KEY_REPEAT_EN
    ,
    parameter int unsigned REP_CNT = DEF_REP_CNT
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic hit
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CNT - 1);
`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REP_CNT - 1);
`endif

    logic             sync1;
    logic             k_s;
    key_state_t       state;
    logic [CNT_W-1:0] cnt;
    // Cleared by reset; set only after a full debounced release so a key that is
    // still held across reset cannot produce a pulse.
    logic             armed;

    // Two-stage synchroniser, preset to the released level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            k_s   <= 1'b1;
        end else begin
            sync1 <= key;
            k_s   <= sync1;
        end
    end

    // Debounce FSM; cnt clears on every state change, hit is a registered strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= KEY_IDLE;
            cnt   <= '0;
            armed <= 1'b0;
            hit   <= 1'b0;
        end else begin
            hit <= 1'b0;
            case (state)
                KEY_IDLE: begin
                    if (!armed) begin
                        if (!k_s) begin
                            cnt <= '0;
                        end else if (cnt == DEB_LAST) begin
                            armed <= 1'b1;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else if (!k_s) begin
                        state <= KEY_PRESS;
                        cnt   <= '0;
                    end
                end

                KEY_PRESS: begin
                    if (k_s) begin
                        state <= KEY_IDLE;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state <= KEY_HELD;
                        cnt   <= '0;
                        hit   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                KEY_HELD: begin
                    if (k_s) begin
                        state <= KEY_REL;
                        cnt   <= '0;
                    end
`ifdef KEY_REPEAT_EN
                    else if (cnt == REP_LAST) begin
                        cnt <= '0;
                        hit <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
`endif
                end

                KEY_REL: begin
                    if (!k_s) begin
                        state <= KEY_HELD;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state <= KEY_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= KEY_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule : key_debounce

// File: rtl/coin_key_filter.sv
// Seller front-end: debounces the coin and money buttons and arbitrates their pulses
// so that flag_coin and flag_money are never high in the same cycle.
// Optional feature macro: KEY_REPEAT_EN (auto-repeat while a key is held).
module coin_key_filter
    import seller_pkg::*;
#(
    parameter int unsigned DEB_CNT = DEF_DEB_CNT,
    parameter int unsigned REP_CNT = DEF_REP_CNT,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_coin,
    input  logic key_money,
    output logic flag_coin,
    output logic flag_money
);

    // Reject configurations where the counters could wrap or debounce is too short.
    if (DEB_CNT < MIN_DEB_CNT || !cnt_fits(DEB_CNT, CNT_W) || !cnt_fits(REP_CNT, CNT_W)) begin : g_cfg_err
        $error("coin_key_filter: illegal DEB_CNT/REP_CNT/CNT_W combination");
    end

    logic hit_coin;
    logic hit_money;
    logic pending;

    key_debounce #(
        .DEB_CNT (DEB_CNT),
        .CNT_W   (CNT_W)
`ifdef KEY_REPEAT_EN
        ,
        .REP_CNT (REP_CNT)
`endif
    ) u_deb_coin (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (key_coin),
        .hit   (hit_coin)
    );

    key_debounce #(
        .DEB_CNT (DEB_CNT),
        .CNT_W   (CNT_W)
`ifdef KEY_REPEAT_EN
        ,
        .REP_CNT (REP_CNT)
`endif
    ) u_deb_money (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (key_money),
        .hit   (hit_money)
    );

    // Coin wins a collision; money is parked in pending and issued on the next coin-free cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag_coin  <= 1'b0;
            flag_money <= 1'b0;
            pending    <= 1'b0;
        end else if (hit_coin) begin
            flag_coin  <= 1'b1;
            flag_money <= 1'b0;
            pending    <= pending | hit_money;
        end else begin
            flag_coin  <= 1'b0;
            flag_money <= pending | hit_money;
            pending    <= pending & hit_money;
        end
    end

endmodule : coin_key_filter

// File: tb/tb_coin_key_filter.sv
// Directed bench for coin_key_filter with DEB_CNT=8, REP_CNT=20, CNT_W=5.
// Cycle c is the clock edge that first samples the pin values driven for c.
module tb_coin_key_filter;

    logic clk = 1'b0;
    logic rst_n;
    logic key_coin;
    logic key_money;
    logic flag_coin;
    logic flag_money;

    int n_tests = 0;
    int n_fail  = 0;
    int coin_q[$];
    int money_q[$];
    int both_cnt;
    int exp_q[$];

    always #5 clk = ~clk;

    coin_key_filter #(
        .DEB_CNT (8),
        .REP_CNT (20),
        .CNT_W   (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_coin   (key_coin),
        .key_money  (key_money),
        .flag_coin  (flag_coin),
        .flag_money (flag_money)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pick(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic clear_log();
        coin_q.delete();
        money_q.delete();
        both_cnt = 0;
    endtask

    // Drive one cycle of inputs, let the edge happen, then log flags mid-cycle.
    task automatic cycle(input logic r, input logic kc, input logic km, input int c);
        rst_n     = r;
        key_coin  = kc;
        key_money = km;
        @(posedge clk);
        @(negedge clk);
        if (flag_coin === 1'b1)  coin_q.push_back(c);
        if (flag_money === 1'b1) money_q.push_back(c);
        if (flag_coin === 1'b1 && flag_money === 1'b1) both_cnt++;
    endtask

    initial begin
        rst_n     = 1'b0;
        key_coin  = 1'b1;
        key_money = 1'b1;

        // 1: reset then idle
        clear_log();
        for (int c = 0; c < 3; c++) cycle(1'b0, 1'b1, 1'b1, c);
        check("rst_coin_lvl", int'(flag_coin), 0);
        check("rst_money_lvl", int'(flag_money), 0);
        check("rst_pulses", coin_q.size() + money_q.size(), 0);
        for (int c = 0; c < 50; c++) cycle(1'b1, 1'b1, 1'b1, c);
        check("idle_coin_n", coin_q.size(), 0);
        check("idle_money_n", money_q.size(), 0);

        // 2: single clean coin press
        clear_log();
        for (int c = 0; c < 30; c++) cycle(1'b1, 1'b0, 1'b1, c);
        for (int c = 30; c < 70; c++) cycle(1'b1, 1'b1, 1'b1, c);
`ifdef KEY_REPEAT_EN
        check("press_coin_n", coin_q.size(), 2);
        check("press_coin_rep", pick(coin_q, 1), 31);
`else
        check("press_coin_n", coin_q.size(), 1);
`endif
        check("press_coin_cyc", pick(coin_q, 0), 11);
        check("press_money_n", money_q.size(), 0);

        // 3: bouncing money key, then a stable press
        clear_log();
        for (int c = 0; c < 24; c++) cycle(1'b1, 1'b1, ((c / 3) % 2 == 0) ? 1'b0 : 1'b1, c);
        for (int c = 24; c < 50; c++) cycle(1'b1, 1'b1, 1'b0, c);
        for (int c = 50; c < 90; c++) cycle(1'b1, 1'b1, 1'b1, c);
        check("bounce_money_n", money_q.size(), 1);
        check("bounce_money_cyc", pick(money_q, 0), 35);
        check("bounce_coin_n", coin_q.size(), 0);

        // 4: simultaneous presses
        clear_log();
        for (int c = 0; c < 25; c++) cycle(1'b1, 1'b0, 1'b0, c);
        for (int c = 25; c < 65; c++) cycle(1'b1, 1'b1, 1'b1, c);
        check("both_coin_n", coin_q.size(), 1);
        check("both_coin_cyc", pick(coin_q, 0), 11);
        check("both_money_n", money_q.size(), 1);
        check("both_money_cyc", pick(money_q, 0), 12);
        check("both_overlap", both_cnt, 0);

        // 5: reset in the middle of a press; only the re-press counts
        clear_log();
        for (int c = 0; c < 30; c++) cycle((c == 6 || c == 7) ? 1'b0 : 1'b1, 1'b0, 1'b1, c);
        for (int c = 30; c < 50; c++) cycle(1'b1, 1'b1, 1'b1, c);
        check("midrst_coin_n0", coin_q.size(), 0);
        for (int c = 50; c < 75; c++) cycle(1'b1, 1'b0, 1'b1, c);
        for (int c = 75; c < 115; c++) cycle(1'b1, 1'b1, 1'b1, c);
        check("midrst_coin_n", coin_q.size(), 1);
        check("midrst_coin_cyc", pick(coin_q, 0), 61);
        check("midrst_money_n", money_q.size(), 0);

        // 6: long hold, repeat behaviour depends on build
        clear_log();
        exp_q.delete();
`ifdef KEY_REPEAT_EN
        exp_q = '{11, 31, 51, 71};
`else
        exp_q = '{11};
`endif
        for (int c = 0; c < 70; c++) cycle(1'b1, 1'b0, 1'b1, c);
        for (int c = 70; c < 130; c++) cycle(1'b1, 1'b1, 1'b1, c);
        check("hold_coin_n", coin_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("hold_coin_cyc%0d", i), pick(coin_q, i), exp_q[i]);
        end
        check("hold_money_n", money_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_coin_key_filter
